// File: rtl/fix_div_seq.sv
// fix_div_seq: sequential signed fixed-point divider (restoring, one quotient bit per cycle) with saturation
module fix_div_seq #(
  parameter int ws = 16,
  parameter int dp = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [ws-1:0] a,
  input  logic [ws-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [ws-1:0] c,
  output logic          ovf,
  output logic          div_zero
);
  localparam int n = ws + dp;
  localparam int cw = $clog2(n);
  localparam logic [n-1:0] pmax = n'((2 ** (ws - 1)) - 1);
  localparam logic [n-1:0] nmax = n'(2 ** (ws - 1));
  localparam logic [ws-1:0] pos_sat = {1'b0, {(ws-1){1'b1}}};
  localparam logic [ws-1:0] neg_sat = {1'b1, {(ws-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q;
  logic busy_q, done_q, ovf_q, dz_q, sgn_q;
  logic [ws-1:0] c_q, bm_q, am, bm, cq;
  logic [ws:0] rem_q, rem_d, sh, df;
  logic [n-1:0] dq_q, dq_d;
  logic [cw-1:0] cnt_q;
  logic qb, sat_p, sat_n;
  assign busy = busy_q;
  assign done = done_q;
  assign c = c_q;
  assign ovf = ovf_q;
  assign div_zero = dz_q;
  // one restoring step plus the signed/saturated result of the quotient it produces
  always_comb begin
    am = a[ws-1] ? -a : a;
    bm = b[ws-1] ? -b : b;
    sh = {rem_q[ws-1:0], dq_q[n-1]};
    df = sh - {1'b0, bm_q};
    qb = sh >= {1'b0, bm_q};
    rem_d = qb ? df : sh;
    dq_d = {dq_q[n-2:0], qb};
    sat_p = !sgn_q && dq_d > pmax;
    sat_n = sgn_q && dq_d > nmax;
    cq = sat_p ? pos_sat : sat_n ? neg_sat : sgn_q ? -dq_d[ws-1:0] : dq_d[ws-1:0];
  end
  // control FSM with registered outputs; dq_q shifts dividend bits out and quotient bits in
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      c_q <= '0;
      ovf_q <= 1'b0;
      dz_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          state_q <= IDLE;
          if (start) begin
            sgn_q <= a[ws-1] ^ b[ws-1];
            bm_q <= bm;
            dq_q <= {am, {dp{1'b0}}};
            rem_q <= '0;
            cnt_q <= cw'(n - 1);
            if (b == '0) begin
              state_q <= DONE;
              done_q <= 1'b1;
              c_q <= a[ws-1] ? neg_sat : pos_sat;
              ovf_q <= 1'b0;
              dz_q <= 1'b1;
            end else begin
              state_q <= CALC;
              busy_q <= 1'b1;
            end
          end
        end
        CALC: begin
          rem_q <= rem_d;
          dq_q <= dq_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            c_q <= cq;
            ovf_q <= sat_p | sat_n;
            dz_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fix_div_seq.sv
// tb_fix_div_seq: table vectors, handshake/reset sequences and random checks against an arithmetic model
module tb_fix_div_seq;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [15:0] a = '0, b = '0, c;
  logic busy, done, ovf, div_zero;
  int n_cmp = 0, n_fail = 0;
  bit busy_bad;
  fix_div_seq dut (.clk(clk), .rst(rst), .start(start), .a(a), .b(b), .busy(busy), .done(done), .c(c), .ovf(ovf), .div_zero(div_zero));
  always #5 clk = ~clk;
  typedef struct {logic [15:0] a, b, c; logic ovf, dz;} vec_t;
  vec_t tbl[9];
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic model(input logic [15:0] x, input logic [15:0] y, output logic [15:0] ec, output logic eo, output logic ez);
    longint ax, ay, q;
    bit neg;
    ez = (y == 0);
    eo = 1'b0;
    if (y == 0) ec = x[15] ? 16'h8000 : 16'h7FFF;
    else begin
      ax = longint'($signed(x));
      ay = longint'($signed(y));
      neg = (ax < 0) != (ay < 0);
      if (ax < 0) ax = -ax;
      if (ay < 0) ay = -ay;
      q = (ax * 256) / ay;
      if (!neg && q > 32767) begin ec = 16'h7FFF; eo = 1'b1; end
      else if (neg && q > 32768) begin ec = 16'h8000; eo = 1'b1; end
      else ec = 16'(neg ? -q : q);
    end
  endtask
  task automatic run_div(input logic [15:0] x, input logic [15:0] y, input bit toggle, output int lat);
    start = 1'b1; a = x; b = y;
    @(posedge clk); #1;
    lat = 1; start = 1'b0; busy_bad = 0;
    while (!done && lat < 40) begin
      if (!busy) busy_bad = 1;
      if (toggle) begin a = 16'($urandom); b = 16'($urandom); start = 1'b1; end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
  endtask
  task automatic chk_zero(input string nm);
    chk({nm, " busy"}, busy, 0);
    chk({nm, " done"}, done, 0);
    chk({nm, " c"}, c, 0);
    chk({nm, " ovf"}, ovf, 0);
    chk({nm, " dz"}, div_zero, 0);
  endtask
  initial begin
    int lat;
    bit seen;
    logic [15:0] ra, rb, ec, hold;
    logic eo, ez;
    tbl[0] = '{16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0};
    tbl[1] = '{16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0};
    tbl[2] = '{16'hFF00, 16'h0300, 16'hFFAB, 1'b0, 1'b0};
    tbl[3] = '{16'hFE80, 16'h0080, 16'hFD00, 1'b0, 1'b0};
    tbl[4] = '{16'h6400, 16'h0040, 16'h7FFF, 1'b1, 1'b0};
    tbl[5] = '{16'h8000, 16'h0080, 16'h8000, 1'b1, 1'b0};
    tbl[6] = '{16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0};
    tbl[7] = '{16'hFF00, 16'h0000, 16'h8000, 1'b0, 1'b1};
    tbl[8] = '{16'h0000, 16'h0000, 16'h7FFF, 1'b0, 1'b1};
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      run_div(tbl[i].a, tbl[i].b, 0, lat);
      chk($sformatf("vec%0d c", i), c, tbl[i].c);
      chk($sformatf("vec%0d ovf", i), ovf, tbl[i].ovf);
      chk($sformatf("vec%0d dz", i), div_zero, tbl[i].dz);
      chk($sformatf("vec%0d latency", i), lat, tbl[i].dz ? 1 : 25);
      chk($sformatf("vec%0d busy_in_done", i), busy, 0);
      chk($sformatf("vec%0d busy_calc", i), busy_bad, 0);
      hold = c;
      @(posedge clk); #1;
      chk($sformatf("vec%0d done_pulse", i), done, 0);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("hold c", c, hold);
    chk("hold dz", div_zero, 1);
    run_div(16'h0300, 16'h0200, 1, lat);
    chk("toggle c", c, 16'h0180);
    chk("toggle latency", lat, 25);
    run_div(16'h0100, 16'h0300, 0, lat);
    chk("b2b latency", lat, 25);
    chk("b2b c", c, 16'h0055);
    start = 1'b1; a = 16'h0300; b = 16'h0200;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_zero("abort");
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    chk("abort no done", seen, 0);
    run_div(16'h0300, 16'h0200, 0, lat);
    chk("after abort c", c, 16'h0180);
    chk("after abort latency", lat, 25);
    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0: rb = 16'h0000;
        1: rb = 16'($urandom_range(1, 255)) ^ ($urandom_range(0, 1) ? 16'hFFFF : 16'h0000);
        default: rb = 16'($urandom);
      endcase
      if ($urandom_range(0, 9) == 0) ra = 16'h8000;
      model(ra, rb, ec, eo, ez);
      run_div(ra, rb, 0, lat);
      chk($sformatf("rnd %h/%h c", ra, rb), c, ec);
      chk($sformatf("rnd %h/%h ovf", ra, rb), ovf, eo);
      chk($sformatf("rnd %h/%h dz", ra, rb), div_zero, ez);
      chk($sformatf("rnd %h/%h latency", ra, rb), lat, ez ? 1 : 25);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
